// File: rtl/bitonic_network_16.sv
// Pipelined 16-input bitonic merger: two ascending 8-tuple vectors in, lower and upper sorted halves out.
// Optional BITONIC_NETWORK_OUT_REG_EN adds one output register stage on data and sidebands (LAT 4 -> 5).
module bitonic_network_16 #(
    parameter int DATA_WIDTH = 128,
    parameter int KEY_WIDTH  = 80
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      switch_output,
    input  logic                      stall,
    input  logic [8*DATA_WIDTH-1:0]   top_tuple,
    input  logic [8*DATA_WIDTH-1:0]   i_elems_0,
    input  logic [8*DATA_WIDTH-1:0]   i_elems_1,
    output logic [8*DATA_WIDTH-1:0]   o_elems_0,
    output logic [8*DATA_WIDTH-1:0]   o_elems_1,
    output logic                      o_switch_output,
    output logic                      o_stall,
    output logic [8*DATA_WIDTH-1:0]   o_top_tuple
);

    localparam int N      = 16;
    localparam int LEVELS = 4;

    logic [DATA_WIDTH-1:0]   net_in   [N];
    logic [DATA_WIDTH-1:0]   lvl_src  [LEVELS][N];
    logic [DATA_WIDTH-1:0]   lvl_next [LEVELS][N];
    logic [DATA_WIDTH-1:0]   lvl_reg  [LEVELS][N];
    logic                    stall_reg [LEVELS];
    logic                    sw_reg    [LEVELS];
    logic [8*DATA_WIDTH-1:0] top_reg   [LEVELS];

    logic [8*DATA_WIDTH-1:0] pipe_elems_0;
    logic [8*DATA_WIDTH-1:0] pipe_elems_1;

    // Second vector enters reversed so the 16 inputs form one bitonic sequence.
    genvar gi, gj;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_in
            assign net_in[gi]     = i_elems_0[gi*DATA_WIDTH +: DATA_WIDTH];
            assign net_in[8 + gi] = i_elems_1[(7-gi)*DATA_WIDTH +: DATA_WIDTH];
            assign pipe_elems_0[gi*DATA_WIDTH +: DATA_WIDTH] = lvl_reg[LEVELS-1][gi];
            assign pipe_elems_1[gi*DATA_WIDTH +: DATA_WIDTH] = lvl_reg[LEVELS-1][8 + gi];
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int D = 8 >> gi;
            for (gj = 0; gj < N; gj++) begin : g_lane
                localparam int LO = gj & ~D;
                localparam int HI = gj | D;
                logic swap;

                if (gi == 0) begin : g_src_in
                    assign lvl_src[gi][gj] = net_in[gj];
                end else begin : g_src_reg
                    assign lvl_src[gi][gj] = lvl_reg[gi-1][gj];
                end

                // Strict compare: equal keys keep their positions.
                assign swap = lvl_src[gi][LO][KEY_WIDTH-1:0] > lvl_src[gi][HI][KEY_WIDTH-1:0];

                if (gj == LO) begin : g_min
                    assign lvl_next[gi][gj] = swap ? lvl_src[gi][HI] : lvl_src[gi][LO];
                end else begin : g_max
                    assign lvl_next[gi][gj] = swap ? lvl_src[gi][LO] : lvl_src[gi][HI];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int e = 0; e < N; e++) begin
                    lvl_reg[l][e] <= '0;
                end
                stall_reg[l] <= 1'b1;
                sw_reg[l]    <= 1'b0;
                top_reg[l]   <= '0;
            end
        end else begin
            for (int l = 0; l < LEVELS; l++) begin
                for (int e = 0; e < N; e++) begin
                    lvl_reg[l][e] <= lvl_next[l][e];
                end
            end
            stall_reg[0] <= stall;
            sw_reg[0]    <= switch_output;
            top_reg[0]   <= top_tuple;
            for (int l = 1; l < LEVELS; l++) begin
                stall_reg[l] <= stall_reg[l-1];
                sw_reg[l]    <= sw_reg[l-1];
                top_reg[l]   <= top_reg[l-1];
            end
        end
    end

`ifdef BITONIC_NETWORK_OUT_REG_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_elems_0       <= '0;
            o_elems_1       <= '0;
            o_switch_output <= 1'b0;
            o_stall         <= 1'b1;
            o_top_tuple     <= '0;
        end else begin
            o_elems_0       <= pipe_elems_0;
            o_elems_1       <= pipe_elems_1;
            o_switch_output <= sw_reg[LEVELS-1];
            o_stall         <= stall_reg[LEVELS-1];
            o_top_tuple     <= top_reg[LEVELS-1];
        end
    end
`else
    assign o_elems_0       = pipe_elems_0;
    assign o_elems_1       = pipe_elems_1;
    assign o_switch_output = sw_reg[LEVELS-1];
    assign o_stall         = stall_reg[LEVELS-1];
    assign o_top_tuple     = top_reg[LEVELS-1];
`endif

endmodule

// File: tb/tb_bitonic_network_16.sv
// Directed bench for bitonic_network_16: reset, merges, duplicates, streaming and mid-stream reset.
module tb_bitonic_network_16;

    localparam int DW = 128;
`ifdef BITONIC_NETWORK_OUT_REG_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            switch_output;
    logic            stall;
    logic [8*DW-1:0] top_tuple;
    logic [8*DW-1:0] i_elems_0;
    logic [8*DW-1:0] i_elems_1;
    logic [8*DW-1:0] o_elems_0;
    logic [8*DW-1:0] o_elems_1;
    logic            o_switch_output;
    logic            o_stall;
    logic [8*DW-1:0] o_top_tuple;

    int checks = 0;
    int errors = 0;

    bitonic_network_16 #(.DATA_WIDTH(128), .KEY_WIDTH(80)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .switch_output   (switch_output),
        .stall           (stall),
        .top_tuple       (top_tuple),
        .i_elems_0       (i_elems_0),
        .i_elems_1       (i_elems_1),
        .o_elems_0       (o_elems_0),
        .o_elems_1       (o_elems_1),
        .o_switch_output (o_switch_output),
        .o_stall         (o_stall),
        .o_top_tuple     (o_top_tuple)
    );

    always #5 i_clk = ~i_clk;

    // Tuple = {48-bit payload, 80-bit key}.
    function automatic logic [DW-1:0] tup(input int pay, input int key);
        return {48'(pay), 80'(key)};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        stall = 1'b1; switch_output = 1'b0;
        top_tuple = '0; i_elems_0 = '0; i_elems_1 = '0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle();
        repeat (2) tick();
        i_rst = 1'b0;
        for (int c = 0; c <= LAT; c++) begin
            checks++;
            if (o_stall !== 1'b1 || o_switch_output !== 1'b0 || o_elems_0 !== '0 ||
                o_elems_1 !== '0 || o_top_tuple !== '0) begin
                errors++;
                $display("FAIL reset cycle %0d: stall=%b sw=%b e0zero=%b e1zero=%b topzero=%b (want 1 0 1 1 1)",
                         c, o_stall, o_switch_output, o_elems_0 == '0, o_elems_1 == '0, o_top_tuple == '0);
            end
            tick();
        end
        $display("reset: idle bubbles checked for %0d cycles", LAT + 1);
    endtask

    task automatic test_interleaved();
        for (int k = 0; k < 8; k++) begin
            i_elems_0[k*DW +: DW] = tup(0, 2*k + 1);
            i_elems_1[k*DW +: DW] = tup(0, 2*k + 2);
        end
        stall = 1'b0;
        repeat (LAT) tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_elems_0[k*DW +: DW] !== tup(0, k + 1) || o_elems_1[k*DW +: DW] !== tup(0, k + 9)) begin
                errors++;
                $display("FAIL interleaved lane %0d: got %h / %h want %h / %h", k,
                         o_elems_0[k*DW +: DW], o_elems_1[k*DW +: DW], tup(0, k + 1), tup(0, k + 9));
            end
        end
        checks++;
        if (o_stall !== 1'b0) begin
            errors++;
            $display("FAIL interleaved stall: got %b want 0", o_stall);
        end
        $display("interleaved: merge of odd/even keys checked");
        idle();
    endtask

    task automatic test_disjoint();
        for (int k = 0; k < 8; k++) begin
            i_elems_0[k*DW +: DW] = tup(3*(9 + k), 9 + k);
            i_elems_1[k*DW +: DW] = tup(3*(1 + k), 1 + k);
        end
        stall = 1'b0;
        repeat (LAT) tick();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_elems_0[k*DW +: DW] !== tup(3*(k + 1), k + 1) ||
                o_elems_1[k*DW +: DW] !== tup(3*(k + 9), k + 9)) begin
                errors++;
                $display("FAIL disjoint lane %0d: got %h / %h want %h / %h", k,
                         o_elems_0[k*DW +: DW], o_elems_1[k*DW +: DW],
                         tup(3*(k + 1), k + 1), tup(3*(k + 9), k + 9));
            end
        end
        $display("disjoint: swapped ranges with payloads checked");
        idle();
    endtask

    task automatic test_duplicates();
        logic [15:0] seen;
        for (int k = 0; k < 8; k++) begin
            i_elems_0[k*DW +: DW] = tup(100 + k, 5);
            i_elems_1[k*DW +: DW] = tup(200 + k, 5);
        end
        stall = 1'b0;
        repeat (LAT) tick();
        // Equal keys never swap, so tuples stay in network input order.
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (o_elems_0[k*DW +: DW] !== tup(100 + k, 5) || o_elems_1[k*DW +: DW] !== tup(207 - k, 5)) begin
                errors++;
                $display("FAIL duplicates lane %0d: got %h / %h want %h / %h", k,
                         o_elems_0[k*DW +: DW], o_elems_1[k*DW +: DW], tup(100 + k, 5), tup(207 - k, 5));
            end
            for (int j = 0; j < 8; j++) begin
                if (o_elems_0[k*DW +: DW] === tup(100 + j, 5) || o_elems1_hit(k, 100 + j)) seen[j] = 1'b1;
                if (o_elems_0[k*DW +: DW] === tup(200 + j, 5) || o_elems1_hit(k, 200 + j)) seen[8 + j] = 1'b1;
            end
        end
        checks++;
        if (seen !== 16'hffff) begin
            errors++;
            $display("FAIL duplicates multiset: payloads seen %h want ffff", seen);
        end
        $display("duplicates: sixteen equal keys checked");
        idle();
    endtask

    function automatic logic o_elems1_hit(input int lane, input int pay);
        return o_elems_1[lane*DW +: DW] === tup(pay, 5);
    endfunction

    task automatic test_back_to_back();
        int idx;
        logic [DW-1:0] exp_lo, exp_hi;
        for (int c = 0; c < 6 + LAT - 1; c++) begin
            if (c < 6) begin
                for (int k = 0; k < 8; k++) begin
                    i_elems_0[k*DW +: DW] = tup(1000 + 16*c + k, 2*k + c);
                    i_elems_1[k*DW +: DW] = tup(2000 + 16*c + k, 2*k + 1 + c);
                    top_tuple[k*DW +: DW] = tup(c + 1, 50 + 8*c + k);
                end
                stall = 1'(c % 2);
                switch_output = ~1'(c % 2);
            end else begin
                idle();
            end
            tick();
            idx = c + 1 - LAT;
            if (idx >= 0 && idx < 6) begin
                for (int k = 0; k < 8; k++) begin
                    exp_lo = (k % 2 == 0) ? tup(1000 + 16*idx + k/2, k + idx)
                                          : tup(2000 + 16*idx + (k-1)/2, k + idx);
                    exp_hi = ((8 + k) % 2 == 0) ? tup(1000 + 16*idx + (8+k)/2, 8 + k + idx)
                                                : tup(2000 + 16*idx + (7+k)/2, 8 + k + idx);
                    checks++;
                    if (o_elems_0[k*DW +: DW] !== exp_lo || o_elems_1[k*DW +: DW] !== exp_hi ||
                        o_top_tuple[k*DW +: DW] !== tup(idx + 1, 50 + 8*idx + k)) begin
                        errors++;
                        $display("FAIL stream vec %0d lane %0d: got %h / %h top %h want %h / %h top %h",
                                 idx, k, o_elems_0[k*DW +: DW], o_elems_1[k*DW +: DW], o_top_tuple[k*DW +: DW],
                                 exp_lo, exp_hi, tup(idx + 1, 50 + 8*idx + k));
                    end
                end
                checks++;
                if (o_stall !== 1'(idx % 2) || o_switch_output !== ~1'(idx % 2)) begin
                    errors++;
                    $display("FAIL stream vec %0d sidebands: stall=%b sw=%b want %b %b",
                             idx, o_stall, o_switch_output, 1'(idx % 2), ~1'(idx % 2));
                end
                $display("stream: vector %0d checked", idx);
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 8; k++) begin
                i_elems_0[k*DW +: DW] = tup(7, 30 + 2*k);
                i_elems_1[k*DW +: DW] = tup(9, 31 + 2*k);
                top_tuple[k*DW +: DW] = tup(11, 1 + k);
            end
            stall = 1'b0;
            switch_output = 1'b1;
            tick();
        end
        idle();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int c = 0; c <= LAT; c++) begin
            checks++;
            if (o_stall !== 1'b1 || o_switch_output !== 1'b0 || o_elems_0 !== '0 ||
                o_elems_1 !== '0 || o_top_tuple !== '0) begin
                errors++;
                $display("FAIL midreset cycle %0d: stall=%b sw=%b e0zero=%b e1zero=%b topzero=%b (want 1 0 1 1 1)",
                         c, o_stall, o_switch_output, o_elems_0 == '0, o_elems_1 == '0, o_top_tuple == '0);
            end
            tick();
        end
        $display("midreset: in-flight vectors discarded");
    endtask

    initial begin
        test_reset();
        test_interleaved();
        test_disjoint();
        test_duplicates();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
